// File: rtl/sprite_ram_loader.sv
// Streams one raster-ordered 16x16 sprite into sprite RAM at {row,col},
// keeping a running modular checksum of the accepted pixels.
module sprite_ram_loader #(
    parameter int DATA_W  = 24,
    parameter int COORD_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_pix_valid,
    input  logic [DATA_W-1:0]      i_pix_data,
    output logic                   o_pix_ready,
    output logic                   o_wr_en,
    output logic [2*COORD_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]      o_wr_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [DATA_W-1:0]      o_checksum
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [COORD_W-1:0]    r_row;
    logic [COORD_W-1:0]    r_col;
    logic [DATA_W-1:0]     r_checksum;
    logic                  r_wr_en;
    logic [2*COORD_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  w_accept;
    logic                  w_last;

    // Abort wins over a beat presented in the same cycle.
    assign w_accept = (r_state == S_LOAD) && i_pix_valid && !i_abort;
    assign w_last   = w_accept && (&r_row) && (&r_col);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_LOAD;
            S_LOAD: begin
                if (i_abort)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_checksum <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (r_state == S_IDLE && i_start) begin
                r_row      <= '0;
                r_col      <= '0;
                r_checksum <= '0;
            end
            if (w_accept) begin
                r_wr_addr  <= {r_row, r_col};
                r_wr_data  <= i_pix_data;
                r_checksum <= r_checksum + i_pix_data;
                r_col      <= r_col + 1'b1;
                if (&r_col) r_row <= r_row + 1'b1;
            end
        end
    end

    assign o_pix_ready = (r_state == S_LOAD);
    assign o_busy      = (r_state == S_LOAD);
    assign o_done      = (r_state == S_DONE);
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed scenarios with randomized valid/data, checked against a beat-level
// model: the k-th accepted pixel lands at address k, checksum is their sum.
module tb_sprite_ram_loader;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [23:0] i_pix_data = '0;
    logic        o_pix_ready, o_wr_en, o_busy, o_done;
    logic [7:0]  o_wr_addr;
    logic [23:0] o_wr_data, o_checksum;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [23:0] exp_sum = '0;
    int          done_cnt = 0;
    int          done_bad = 0;
    logic [23:0] done_cs = '0;

    sprite_ram_loader #(.DATA_W(24), .COORD_W(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
        .o_pix_ready(o_pix_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done),
        .o_checksum(o_checksum)
    );

    always #5 clk = ~clk;

    // Observe the write port and done pulse mid-cycle.
    always @(negedge clk) begin
        if (o_wr_en) got_q.push_back({o_wr_addr, o_wr_data});
        if (o_done) begin
            done_cnt++;
            done_cs = o_checksum;
            if (!(o_wr_en && o_wr_addr == 8'hFF && !o_busy && !o_pix_ready)) done_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, o_pix_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
        chk({tag, "_addr"}, {24'd0, o_wr_addr}, 32'd0);
        chk({tag, "_data"}, {8'd0, o_wr_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_cs"}, {8'd0, o_checksum}, 32'd0);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        done_bad = 0;
    endtask

    task automatic do_start(input string tag);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        exp_sum = '0;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        chk({tag, "_ready"}, {31'd0, o_pix_ready}, 32'd1);
        chk({tag, "_cs_clr"}, {8'd0, o_checksum}, 32'd0);
    endtask

    // mode 0: pixel = index, 1: all ones, 2: random with index in low byte
    task automatic stream(input string tag, input int n_pix, input bit bubbles,
                          input int mode, input int abort_at, input int start_at,
                          input int rst_at);
        int          idx = 0;
        int          cyc = 0;
        bit          stop = 0;
        bit          v;
        logic [23:0] pix;
        logic [7:0]  a;
        while (idx < n_pix && cyc < 4000) begin
            v = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            a = idx[7:0];
            case (mode)
                0:       pix = {16'd0, a};
                1:       pix = 24'hFFFFFF;
                default: pix = {$urandom_range(0, 65535) & 16'hFFFF, a};
            endcase
            i_pix_valid = v;
            i_pix_data  = v ? pix : 24'($urandom);
            if (idx == abort_at && v) begin i_abort = 1'b1; stop = 1; end
            if (idx == rst_at && v)   begin i_rst = 1'b1;   stop = 1; end
            if (idx == start_at && v) i_start = 1'b1;
            @(posedge clk); #1;
            i_abort = 1'b0; i_rst = 1'b0; i_start = 1'b0;
            if (stop) break;
            if (v) begin
                exp_q.push_back({a, pix});
                exp_sum += pix;
                idx++;
            end
            cyc++;
        end
        i_pix_valid = 1'b0;
        chk({tag, "_progress"}, {31'd0, (stop || idx == n_pix)}, 32'd1);
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_wr_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic chk_full(input string tag);
        cmp_writes(tag);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_done_bad"}, done_bad, 32'd0);
        chk({tag, "_done_cs"}, {8'd0, done_cs}, {8'd0, exp_sum});
        chk({tag, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, o_pix_ready}, 32'd0);
        chk({tag, "_cs_hold"}, {8'd0, o_checksum}, {8'd0, exp_sum});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        clear_obs();

        // Full load, continuous valid, pixels 0..255
        do_start("full_start");
        stream("full", 256, 0, 0, -1, -1, -1);
        chk_full("full");
        clear_obs();

        // Same stream with bubbles
        do_start("bub_start");
        stream("bub", 256, 1, 0, -1, -1, -1);
        chk_full("bub");
        clear_obs();

        // Abort after 100 beats, a valid beat present in the abort cycle
        do_start("abort_start");
        stream("abort", 256, 1, 0, 100, -1, -1);
        @(negedge clk);
        chk("abort_ready", {31'd0, o_pix_ready}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_wr_en", {31'd0, o_wr_en}, 32'd0);
        cmp_writes("abort");
        chk("abort_done_cnt", done_cnt, 32'd0);
        chk("abort_cs", {8'd0, o_checksum}, {8'd0, exp_sum});
        clear_obs();

        // Restart with all-ones pixels
        do_start("ones_start");
        stream("ones", 256, 0, 1, -1, -1, -1);
        chk_full("ones");
        clear_obs();

        // i_start while loading must be ignored
        do_start("sbusy_start");
        stream("sbusy", 256, 1, 2, -1, 50, -1);
        chk_full("sbusy");
        clear_obs();

        // Reset mid-load, then a fresh random load
        do_start("mrst_start");
        stream("mrst", 256, 1, 2, -1, -1, 30);
        @(negedge clk);
        chk_reset_outputs("mrst");
        cmp_writes("mrst");
        chk("mrst_done_cnt", done_cnt, 32'd0);
        clear_obs();
        do_start("post_start");
        stream("post", 256, 1, 2, -1, -1, -1);
        chk_full("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
